// File: rtl/interval_scheduler_pkg.sv
// Shared constants for the interval scheduler: FSM state codes and time units.
package interval_scheduler_pkg;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_ON    = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    localparam int SEC_PER_MIN = 60;

    function automatic int rr_next(input int ch, input int n);
        return (ch + 1) % n;
    endfunction

endpackage

// File: rtl/interval_scheduler_if.sv
// Configuration, sensor and actuator signals of the interval scheduler.
interface interval_scheduler_if #(
    parameter int N_CH = 4,
    parameter int CH_W = 2
);
    logic              enable;
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [15:0]       cfg_interval;
    logic [N_CH-1:0]   full_sensor;
    logic              act_on;
    logic [CH_W-1:0]   act_ch;
    logic [N_CH-1:0]   pending;
    logic [N_CH-1:0]   overrun;

    modport master (
        output enable, cfg_we, cfg_ch, cfg_interval, full_sensor,
        input  act_on, act_ch, pending, overrun
    );

    modport slave (
        input  enable, cfg_we, cfg_ch, cfg_interval, full_sensor,
        output act_on, act_ch, pending, overrun
    );
endinterface

// File: rtl/interval_scheduler_channel_timer.sv
// Per-channel interval timer: seconds counter, programmed interval, due flag, overrun pulse.
module sched_channel_timer #(
    parameter int CNT_W = 21
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tick,
    input  logic             cfg_load,
    input  logic [CNT_W-1:0] cfg_isec,
    input  logic             full,
    input  logic             grant_clr,
    output logic             pending,
    output logic             overrun
);
    logic [CNT_W-1:0] isec;
    logic [CNT_W-1:0] cnt;
    logic             wrap;

    assign wrap = tick && (isec != '0) && (cnt == isec - CNT_W'(1));

    always_ff @(posedge clock) begin
        if (reset) begin
            isec    <= '0;
            cnt     <= '0;
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (cfg_load) begin
                isec    <= cfg_isec;
                cnt     <= '0;
                pending <= 1'b0;
            end else if (full) begin
                cnt     <= '0;
                pending <= 1'b0;
            end else if (isec == '0) begin
                cnt <= '0;
            end else if (wrap) begin
                // a wrap wins over a same-cycle grant so the new due event is not lost
                cnt     <= '0;
                pending <= 1'b1;
                overrun <= pending;
            end else begin
                if (tick) cnt <= cnt + CNT_W'(1);
                if (grant_clr) pending <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/interval_scheduler.sv
// Shares one actuator between channels: prescaler, per-channel timers, round-robin grant FSM.
//  state | meaning
//  IDLE  | waiting for an eligible due channel
//  GRANT | pick winner, latch act_ch, load on-time
//  ON    | actuator driven for ON_SECONDS ticks
//  GAP   | one break-before-make cycle with actuator off
module interval_scheduler
    import interval_scheduler_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int CH_W       = 2,
    parameter int CNT_W      = 21,
    parameter int TICK_DIV   = 1,
    parameter int ON_SECONDS = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    interval_scheduler_if.slave  bus
);
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int ON_W  = $clog2(ON_SECONDS + 1);

    logic [PRE_W-1:0] pre_cnt;
    logic             tick;
    state_t           state;
    logic [ON_W-1:0]  on_cnt;
    logic [CH_W-1:0]  rr_ptr;
    logic [CH_W-1:0]  act_ch;
    logic             act_on;
    logic [CH_W-1:0]  winner;
    logic             found;
    logic [N_CH-1:0]  elig;
    logic [N_CH-1:0]  pend;
    logic [N_CH-1:0]  ovr;
    logic [N_CH-1:0]  grant_clr;
    logic [CNT_W-1:0] cfg_isec;
    logic             cfg_hit_win;
    logic             abort_act;

    always_ff @(posedge clock) begin
        if (reset) begin
            pre_cnt <= PRE_W'(TICK_DIV - 1);
        end else if (bus.enable) begin
            if (pre_cnt == '0) pre_cnt <= PRE_W'(TICK_DIV - 1);
            else               pre_cnt <= pre_cnt - PRE_W'(1);
        end
    end

    assign tick     = bus.enable && (pre_cnt == '0);
    assign cfg_isec = CNT_W'(bus.cfg_interval) * CNT_W'(SEC_PER_MIN);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        sched_channel_timer #(.CNT_W(CNT_W)) u_timer (
            .clock     (clock),
            .reset     (reset),
            .tick      (tick),
            .cfg_load  (bus.cfg_we && (int'(bus.cfg_ch) == i)),
            .cfg_isec  (cfg_isec),
            .full      (bus.full_sensor[i]),
            .grant_clr (grant_clr[i]),
            .pending   (pend[i]),
            .overrun   (ovr[i])
        );
    end

    assign elig = pend & ~bus.full_sensor;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (!found && elig[(int'(rr_ptr) + k) % N_CH]) begin
                found  = 1'b1;
                winner = CH_W'((int'(rr_ptr) + k) % N_CH);
            end
        end
    end

    always_comb begin
        grant_clr = '0;
        if (state == ST_GRANT && found) grant_clr[winner] = 1'b1;
    end

    assign cfg_hit_win = bus.cfg_we && (bus.cfg_ch == winner);
    assign abort_act   = bus.full_sensor[act_ch] || (bus.cfg_we && (bus.cfg_ch == act_ch));

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= ST_IDLE;
            on_cnt <= '0;
            rr_ptr <= '0;
            act_ch <= '0;
            act_on <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.enable && (|elig)) state <= ST_GRANT;
                end
                ST_GRANT: begin
                    if (!found) begin
                        state <= ST_IDLE;
                    end else begin
                        act_ch <= winner;
                        rr_ptr <= CH_W'(rr_next(int'(winner), N_CH));
                        on_cnt <= ON_W'(ON_SECONDS - 1);
                        if (cfg_hit_win) begin
                            state <= ST_GAP;
                        end else begin
                            state  <= ST_ON;
                            act_on <= 1'b1;
                        end
                    end
                end
                ST_ON: begin
                    // enable only freezes the tick; it never cuts a running grant short
                    if (abort_act || (tick && on_cnt == '0)) begin
                        state  <= ST_GAP;
                        act_on <= 1'b0;
                    end else if (tick) begin
                        on_cnt <= on_cnt - ON_W'(1);
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    act_on <= 1'b0;
                end
            endcase
        end
    end

    assign bus.act_on  = act_on;
    assign bus.act_ch  = act_ch;
    assign bus.pending = pend;
    assign bus.overrun = ovr;
endmodule

// File: tb/tb_interval_scheduler.sv
// Scoreboard bench: two schedulers (short and long on-time) against a behavioural model.
module tb_interval_scheduler;
    typedef struct packed {
        logic       on;
        logic [1:0] ch;
        logic [3:0] pend;
        logic [3:0] ovr;
    } obs_t;

    localparam int P_IDLE = 0, P_GRANT = 1, P_ON = 2, P_GAP = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_interval;
    logic [3:0]  full_sensor;

    int total = 0;
    int bad   = 0;

    obs_t q0[$];
    obs_t q1[$];

    int m_isec  [2][4];
    int m_age   [2][4];
    bit m_pend  [2][4];
    bit m_ovr   [2][4];
    int m_phase [2];
    int m_owner [2];
    int m_rr    [2];
    int m_served[2];
    bit m_on    [2];

    int low_run [2];
    bit seen_on [2];
    bit prev_on [2];

    always #5 clock = ~clock;

    interval_scheduler_if #(.N_CH(4), .CH_W(2)) if_a ();
    interval_scheduler_if #(.N_CH(4), .CH_W(2)) if_b ();

    assign if_a.enable = enable;        assign if_b.enable = enable;
    assign if_a.cfg_we = cfg_we;        assign if_b.cfg_we = cfg_we;
    assign if_a.cfg_ch = cfg_ch;        assign if_b.cfg_ch = cfg_ch;
    assign if_a.cfg_interval = cfg_interval;
    assign if_b.cfg_interval = cfg_interval;
    assign if_a.full_sensor = full_sensor;
    assign if_b.full_sensor = full_sensor;

    interval_scheduler #(.N_CH(4), .CH_W(2), .CNT_W(21), .TICK_DIV(1), .ON_SECONDS(5)) dut_a (
        .clock (clock), .reset (reset), .bus (if_a));
    interval_scheduler #(.N_CH(4), .CH_W(2), .CNT_W(21), .TICK_DIV(1), .ON_SECONDS(70)) dut_b (
        .clock (clock), .reset (reset), .bus (if_b));

    // Reference: seconds since (re)start per channel; due whenever that age is a multiple of the interval.
    task automatic model_step(input int k, input int on_s);
        bit [3:0] elig;
        bit [3:0] pv;
        bit [3:0] ov;
        int       w;
        int       gclr;
        int       nph;
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                m_isec[k][i] = 0; m_age[k][i] = 0; m_pend[k][i] = 0; m_ovr[k][i] = 0;
            end
            m_phase[k] = P_IDLE; m_owner[k] = 0; m_rr[k] = 0; m_served[k] = 0; m_on[k] = 0;
        end else begin
            for (int i = 0; i < 4; i++) elig[i] = m_pend[k][i] && !full_sensor[i];
            gclr = -1;
            nph  = m_phase[k];
            case (m_phase[k])
                P_IDLE:  if (enable && elig != 0) nph = P_GRANT;
                P_GRANT: begin
                    w = -1;
                    for (int j = 0; j < 4; j++)
                        if (w < 0 && elig[(m_rr[k] + j) % 4]) w = (m_rr[k] + j) % 4;
                    if (w < 0) nph = P_IDLE;
                    else begin
                        m_owner[k] = w; gclr = w; m_rr[k] = (w + 1) % 4; m_served[k] = 0;
                        nph = (cfg_we && int'(cfg_ch) == w) ? P_GAP : P_ON;
                    end
                end
                P_ON: begin
                    if (full_sensor[m_owner[k]] || (cfg_we && int'(cfg_ch) == m_owner[k])) nph = P_GAP;
                    else if (enable) begin
                        m_served[k]++;
                        if (m_served[k] == on_s) nph = P_GAP;
                    end
                end
                default: nph = P_IDLE;
            endcase
            for (int i = 0; i < 4; i++) begin
                m_ovr[k][i] = 0;
                if (cfg_we && int'(cfg_ch) == i) begin
                    m_isec[k][i] = 60 * int'(cfg_interval); m_age[k][i] = 0; m_pend[k][i] = 0;
                end else if (full_sensor[i]) begin
                    m_age[k][i] = 0; m_pend[k][i] = 0;
                end else if (m_isec[k][i] == 0) begin
                    m_age[k][i] = 0;
                end else begin
                    if (enable) m_age[k][i]++;
                    if (enable && (m_age[k][i] % m_isec[k][i]) == 0) begin
                        m_ovr[k][i] = m_pend[k][i]; m_pend[k][i] = 1;
                    end else if (gclr == i) m_pend[k][i] = 0;
                end
            end
            m_phase[k] = nph;
            m_on[k]    = (nph == P_ON);
        end
        for (int i = 0; i < 4; i++) begin pv[i] = m_pend[k][i]; ov[i] = m_ovr[k][i]; end
        if (k == 0) q0.push_back(obs_t'{m_on[k], 2'(m_owner[k]), pv, ov});
        else        q1.push_back(obs_t'{m_on[k], 2'(m_owner[k]), pv, ov});
    endtask

    always @(posedge clock) begin
        model_step(0, 5);
        model_step(1, 70);
    end

    task automatic check_obs(input int k, input obs_t got);
        obs_t exp_o;
        total++;
        if ((k == 0 ? q0.size() : q1.size()) == 0) begin
            bad++;
            $display("FAIL sb_empty_%0d at %0t: got %h, expected an entry", k, $time, got);
        end else begin
            exp_o = (k == 0) ? q0.pop_front() : q1.pop_front();
            if (got !== exp_o) begin
                bad++;
                $display("FAIL cycle_%0d at %0t: got on=%b ch=%0d pend=%b ovr=%b, expected on=%b ch=%0d pend=%b ovr=%b",
                         k, $time, got.on, got.ch, got.pend, got.ovr, exp_o.on, exp_o.ch, exp_o.pend, exp_o.ovr);
            end
        end
        if (got.on === 1'b1 && !prev_on[k] && seen_on[k]) begin
            total++;
            if (low_run[k] < 2) begin
                bad++;
                $display("FAIL off_gap_%0d at %0t: got %0d off cycles, expected >= 2", k, $time, low_run[k]);
            end
        end
        if (got.on === 1'b1) begin seen_on[k] = 1; low_run[k] = 0; end
        else low_run[k]++;
        prev_on[k] = (got.on === 1'b1);
    endtask

    always @(negedge clock) begin
        check_obs(0, obs_t'{if_a.act_on, if_a.act_ch, if_a.pending, if_a.overrun});
        check_obs(1, obs_t'{if_b.act_on, if_b.act_ch, if_b.pending, if_b.overrun});
    end

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic cfg(input int ch, input int iv);
        @(negedge clock);
        cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_interval = 16'(iv);
        @(negedge clock);
        cfg_we = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_interval = '0; full_sensor = '0;
        idle_cycles(3);
        reset = 1'b0; enable = 1'b1;

        cfg(0, 1); idle_cycles(80);
        cfg(0, 1); cfg(1, 1); cfg(3, 1); idle_cycles(260);

        cfg(0, 1); idle_cycles(63);
        full_sensor[0] = 1'b1; idle_cycles(20);
        full_sensor[0] = 1'b0; idle_cycles(80);

        cfg(2, 0); cfg(1, 2); idle_cycles(400);

        @(negedge clock); reset = 1'b1;
        @(negedge clock); reset = 1'b0;
        cfg(0, 1); cfg(1, 1); idle_cycles(320);

        cfg(0, 1); idle_cycles(63);
        reset = 1'b1; @(negedge clock); reset = 1'b0;
        idle_cycles(200);

        for (int c = 0; c < 4000; c++) begin
            @(negedge clock);
            reset        = ($urandom_range(999) < 2);
            enable       = ($urandom_range(99) < 95);
            cfg_we       = ($urandom_range(99) < 1);
            cfg_ch       = 2'($urandom_range(3));
            cfg_interval = 16'($urandom_range(2));
            if ($urandom_range(99) == 0) full_sensor[$urandom_range(3)] ^= 1'b1;
        end

        @(negedge clock);
        reset = 1'b0; enable = 1'b1; cfg_we = 1'b0; full_sensor = '0;
        idle_cycles(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
